// File: rtl/text_grid_panel.sv
// -----------------------------------------------------------------------------
// text_grid_panel
//
// Runtime-writable ROWS x COLS text panel for the VGA overlay path.
// The character buffer is filled through a simple write port, can be blanked
// by a full-buffer clear sweep, and shows a blinking inverted cursor.
// Pixels go through a fixed 3-stage pipeline:
//   stage 1 : region flags, buffer address, glyph offsets, cursor hit
//   stage 2 : buffer read data and delayed flags
//   stage 3 : final colour and enable
//
// Ports
//   vga_clk   pixel clock (sole clock)
//   rst       synchronous active-high reset; starts a clear sweep
//   pos_x/y   current pixel coordinate
//   wr_en     single-cycle write strobe (wr_row, wr_col, wr_char)
//   clr       single-cycle clear request
//   cur_en    cursor display enable, cur_row/cur_col cursor cell
//   busy      clear sweep in progress (writes and clr are ignored)
//   enable    pixel lies inside the panel (aligned with pos_data)
//   pos_data  pixel colour
//
// The vga_ascii character generator lives at the bottom of this file.
// -----------------------------------------------------------------------------
module text_grid_panel #(
  parameter int          CHAR_W      = 8,
  parameter int          CHAR_H      = 16,
  parameter int          COLS        = 16,
  parameter int          ROWS        = 4,
  parameter int          PANEL_X     = 64,
  parameter int          PANEL_Y     = 64,
  parameter int          PANEL_W     = 240,
  parameter int          PANEL_H     = 96,
  parameter int          TEXT_X      = 16,
  parameter int          TEXT_Y      = 16,
  parameter logic [23:0] PANEL_COLOR = 24'hFFFFFF,
  parameter int          BLINK_HALF  = 12_500_000
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic        wr_en,
  input  logic [3:0]  wr_row,
  input  logic [5:0]  wr_col,
  input  logic [7:0]  wr_char,
  input  logic        clr,
  input  logic        cur_en,
  input  logic [3:0]  cur_row,
  input  logic [5:0]  cur_col,
  output logic        busy,
  output logic        enable,
  output logic [23:0] pos_data
);

  localparam int CELLS = ROWS * COLS;
  localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int XS    = $clog2(CHAR_W);
  localparam int YS    = $clog2(CHAR_H);
  localparam int XW    = (XS > 0) ? XS : 1;
  localparam int YW    = (YS > 0) ? YS : 1;
  localparam int BW    = $clog2(BLINK_HALF);

  // Region bounds widened to 11 bits so right/bottom edges never wrap.
  localparam logic [10:0] PX0 = 11'(PANEL_X);
  localparam logic [10:0] PX1 = 11'(PANEL_X + PANEL_W);
  localparam logic [10:0] PY0 = 11'(PANEL_Y);
  localparam logic [10:0] PY1 = 11'(PANEL_Y + PANEL_H);
  localparam logic [10:0] TX0 = 11'(PANEL_X + TEXT_X);
  localparam logic [10:0] TX1 = 11'(PANEL_X + TEXT_X + COLS * CHAR_W);
  localparam logic [10:0] TY0 = 11'(PANEL_Y + TEXT_Y);
  localparam logic [10:0] TY1 = 11'(PANEL_Y + TEXT_Y + ROWS * CHAR_H);
  localparam logic [10:0] XMASK = 11'(CHAR_W - 1);
  localparam logic [10:0] YMASK = 11'(CHAR_H - 1);
  localparam logic [10:0] COLS_M = 11'(COLS);
  localparam logic [4:0]  ROWS_L = 5'(ROWS);
  localparam logic [6:0]  COLS_L = 7'(COLS);

  localparam logic [AW-1:0] LAST_IDX   = AW'(CELLS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [7:0]    BLANK_CHAR = 8'h20;

  // ---------------------------------------------------------------------------
  // Clear sweep FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [0:0] {ST_IDLE, ST_SWEEP} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] idx_reg, idx_next;
  logic          sweep_we;

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state_reg <= ST_SWEEP;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      ST_IDLE: begin
        if (clr) begin
          state_next = ST_SWEEP;
          idx_next   = '0;
        end
      end
      ST_SWEEP: begin
        if (idx_reg == LAST_IDX) begin
          state_next = ST_IDLE;
          idx_next   = '0;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // The RAM is left untouched while rst is held; the sweep proper starts on
  // the first edge after rst falls.
  always_comb begin
    busy     = (state_reg == ST_SWEEP);
    sweep_we = (state_reg == ST_SWEEP) && !rst;
  end

  // ---------------------------------------------------------------------------
  // Write port qualification
  // ---------------------------------------------------------------------------
  logic          wr_ok;
  logic [10:0]   wr_lin;
  logic [AW-1:0] wr_addr;

  always_comb begin
    // clr wins over a same-cycle write, and the sweep owns the RAM while busy.
    wr_ok   = wr_en && !busy && !clr &&
              ({1'b0, wr_row} < ROWS_L) && ({1'b0, wr_col} < COLS_L);
    wr_lin  = 11'(wr_row) * COLS_M + 11'(wr_col);
    wr_addr = AW'(wr_lin);
  end

  // ---------------------------------------------------------------------------
  // Character buffer: one write port, one registered read port
  // ---------------------------------------------------------------------------
  logic [7:0]    char_mem [0:CELLS-1];
  logic [AW-1:0] addr_s1_reg;
  logic [7:0]    char_s2_reg;

  always_ff @(posedge vga_clk) begin
    if (sweep_we) begin
      char_mem[idx_reg] <= BLANK_CHAR;
    end else if (wr_ok) begin
      char_mem[wr_addr] <= wr_char;
    end
  end

  // Read-before-write: a same-edge write to this address is not seen.
  always_ff @(posedge vga_clk) begin
    char_s2_reg <= char_mem[addr_s1_reg];
  end

  // ---------------------------------------------------------------------------
  // Cursor blink timer
  // ---------------------------------------------------------------------------
  logic [BW-1:0] blink_cnt_reg;
  logic          blink_on_reg;

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      blink_cnt_reg <= '0;
      blink_on_reg  <= 1'b1;
    end else if (blink_cnt_reg == BLINK_LAST) begin
      blink_cnt_reg <= '0;
      blink_on_reg  <= !blink_on_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: region decode, cell address, glyph offsets, cursor hit
  // ---------------------------------------------------------------------------
  logic [10:0]   px, py, tx, ty, col_c, row_c;
  logic          in_panel_c, in_text_c, cur_valid_c, hit_c;
  logic [XW-1:0] xo_c;
  logic [YW-1:0] yo_c;
  logic [AW-1:0] addr_c;

  always_comb begin
    px         = {1'b0, pos_x};
    py         = {1'b0, pos_y};
    in_panel_c = (px >= PX0) && (px < PX1) && (py >= PY0) && (py < PY1);
    in_text_c  = (px >= TX0) && (px < TX1) && (py >= TY0) && (py < TY1);
    // Offsets are only meaningful inside the text rectangle; outside it the
    // wrapped values feed a harmless RAM read.
    tx         = px - TX0;
    ty         = py - TY0;
    col_c      = tx >> XS;
    row_c      = ty >> YS;
    xo_c       = XW'(tx & XMASK);
    yo_c       = YW'(ty & YMASK);
    addr_c     = AW'(row_c * COLS_M + col_c);
    // An off-grid cursor never matches, even if it aliases onto a real cell.
    cur_valid_c = ({1'b0, cur_row} < ROWS_L) && ({1'b0, cur_col} < COLS_L);
    hit_c       = cur_en && blink_on_reg && cur_valid_c &&
                  (row_c == {7'd0, cur_row}) && (col_c == {5'd0, cur_col});
  end

  logic          in_panel_s1_reg, in_text_s1_reg, hit_s1_reg;
  logic [XW-1:0] xo_s1_reg;
  logic [YW-1:0] yo_s1_reg;

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      in_panel_s1_reg <= 1'b0;
      in_text_s1_reg  <= 1'b0;
      hit_s1_reg      <= 1'b0;
      xo_s1_reg       <= '0;
      yo_s1_reg       <= '0;
      addr_s1_reg     <= '0;
    end else begin
      in_panel_s1_reg <= in_panel_c;
      in_text_s1_reg  <= in_text_c;
      hit_s1_reg      <= hit_c;
      xo_s1_reg       <= xo_c;
      yo_s1_reg       <= yo_c;
      addr_s1_reg     <= addr_c;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: delayed flags alongside the RAM read data
  // ---------------------------------------------------------------------------
  logic          in_panel_s2_reg, in_text_s2_reg, hit_s2_reg;
  logic [XW-1:0] xo_s2_reg;
  logic [YW-1:0] yo_s2_reg;

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      in_panel_s2_reg <= 1'b0;
      in_text_s2_reg  <= 1'b0;
      hit_s2_reg      <= 1'b0;
      xo_s2_reg       <= '0;
      yo_s2_reg       <= '0;
    end else begin
      in_panel_s2_reg <= in_panel_s1_reg;
      in_text_s2_reg  <= in_text_s1_reg;
      hit_s2_reg      <= hit_s1_reg;
      xo_s2_reg       <= xo_s1_reg;
      yo_s2_reg       <= yo_s1_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: glyph lookup and colour select
  // ---------------------------------------------------------------------------
  logic [23:0] glyph_pix;
  logic [23:0] pix_next;

  vga_ascii #(
    .XW (XW),
    .YW (YW)
  ) u_ascii (
    .ascii    (char_s2_reg),
    .x_over   (xo_s2_reg),
    .y_over   (yo_s2_reg),
    .pix_data (glyph_pix)
  );

  always_comb begin
    pix_next = 24'h000000;
    if (in_panel_s2_reg) begin
      if (!in_text_s2_reg) begin
        pix_next = PANEL_COLOR;
      end else if (hit_s2_reg) begin
        pix_next = ~glyph_pix;
      end else begin
        pix_next = glyph_pix;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      pos_data <= 24'h000000;
      enable   <= 1'b0;
    end else begin
      pos_data <= pix_next;
      enable   <= in_panel_s2_reg;
    end
  end

endmodule

// -----------------------------------------------------------------------------
// vga_ascii
//
// Combinational character generator used by the text panels.
// Glyph set: the space character and the cell's top row / left column are
// background; any other pixel is foreground when bit ((x_over+y_over) mod 8)
// of the character code is set.
//
// Ports
//   ascii     character code
//   x_over    pixel column inside the glyph cell
//   y_over    pixel row inside the glyph cell
//   pix_data  24-bit pixel colour
// -----------------------------------------------------------------------------
module vga_ascii #(
  parameter int XW = 3,
  parameter int YW = 4
) (
  input  logic [7:0]    ascii,
  input  logic [XW-1:0] x_over,
  input  logic [YW-1:0] y_over,
  output logic [23:0]   pix_data
);

  localparam logic [23:0] GLYPH_FG = 24'h00FF00;
  localparam logic [23:0] GLYPH_BG = 24'h101010;

  logic [2:0] bit_sel;
  logic       pix_on;

  always_comb begin
    bit_sel  = 3'(x_over) + 3'(y_over);
    pix_on   = (ascii != 8'h20) && (x_over != '0) && (y_over != '0) &&
               ascii[bit_sel];
    pix_data = pix_on ? GLYPH_FG : GLYPH_BG;
  end

endmodule

// File: doc/text_grid_panel.md
# text_grid_panel

Runtime-writable, multi-row text panel for the VGA overlay path. It holds a ROWS×COLS character buffer that control logic fills through a write port, and adds a full-buffer clear sweep and a blinking inverted cursor. For each (pos_x, pos_y) it produces panel pixel colour and an enable through a fixed 3-cycle pipeline. It sits beside the static panel blocks and feeds the same pixel mux; glyphs come from the existing `vga_ascii` module.

## Interface
Parameters:
- CHAR_W, 8, glyph width in pixels; power of two
- CHAR_H, 16, glyph height in pixels; power of two
- COLS, 16, characters per row (1..64)
- ROWS, 4, text rows (1..16)
- PANEL_X, 64, panel left edge (screen px)
- PANEL_Y, 64, panel top edge (screen px)
- PANEL_W, 240, panel width in px
- PANEL_H, 96, panel height in px
- TEXT_X, 16, text area x offset inside panel; TEXT_X+COLS*CHAR_W ≤ PANEL_W
- TEXT_Y, 16, text area y offset inside panel; TEXT_Y+ROWS*CHAR_H ≤ PANEL_H
- PANEL_COLOR, 24'hFFFFFF, fill colour outside the text area
- BLINK_HALF, 12_500_000, vga_clk cycles per cursor blink half-period (≥2)

Ports:
- vga_clk  in  1  pixel clock; sole clock
- rst  in  1  synchronous, active-high reset
- pos_x  in  10  current pixel x
- pos_y  in  10  current pixel y
- wr_en  in  1  single-cycle character write strobe
- wr_row  in  4  write row
- wr_col  in  6  write column
- wr_char  in  8  ASCII code to write
- clr  in  1  single-cycle clear request
- cur_en  in  1  cursor display enable
- cur_row  in  4  cursor row
- cur_col  in  6  cursor column
- busy  out  1  clear sweep in progress; writes and clr are ignored
- enable  out  1  pixel lies inside the panel (delayed, aligned with pos_data)
- pos_data  out  24  pixel colour

## Operation
- Region tests are unsigned with no wrap: in_panel = PANEL_X ≤ pos_x < PANEL_X+PANEL_W and PANEL_Y ≤ pos_y < PANEL_Y+PANEL_H. in_text uses the same form on the text rectangle.
- Cell: col = (pos_x−PANEL_X−TEXT_X)/CHAR_W; row = (pos_y−PANEL_Y−TEXT_Y)/CHAR_H; x_over and y_over are the remainders. All are computed by shift/mask.
- Buffer: ROWS*COLS×8 bits, one synchronous read port (pixel path) and one write port. Address = row*COLS+col.
- Write: when wr_en=1, busy=0, clr=0, wr_row<ROWS and wr_col<COLS, wr_char is stored at the next edge. Out-of-range writes are dropped silently.
- Clear FSM states:
  - IDLE→SWEEP on clr=1 while busy=0. clr wins over a same-cycle wr_en, whose write is dropped.
  - SWEEP writes 8'h20 to address idx and increments idx once per cycle.
  - At idx=ROWS*COLS−1 the FSM writes that cell and returns to IDLE.
  - busy=1 throughout SWEEP, exactly ROWS*COLS cycles. clr during SWEEP is ignored.
- Blink: counter runs 0..BLINK_HALF−1. At wrap it clears and toggles blink_on.
- Pixel colour, decided per pixel:
  - outside panel: 24'h000000
  - in panel, outside text: PANEL_COLOR
  - in text: glyph = vga_ascii(buffer char, x_over, y_over).pix_data
  - cursor cell (cur_en=1, blink_on=1, row=cur_row, col=cur_col, cursor in range): ~glyph
  - any other text cell: glyph
- Out-of-range cursor position: no cursor is drawn.
- cur_* and cur_en are sampled in pipeline stage 1 with the pixel.

## Timing
- Pipeline: pos_x/pos_y present at edge k.
  - Edge k+1 registers region flags, address, offsets and cursor-hit.
  - Edge k+2 registers buffer data and the delayed flags.
  - Edge k+3 registers pos_data and enable.
  - Latency is exactly 3 cycles; throughput is 1 pixel per cycle.
- A write accepted at edge t is visible to a pixel whose address is registered at edge ≥ t+1. Same-cycle read/write of one address returns the old data.
- Reset, while rst=1:
  - pos_data=0, enable=0, pipeline flags 0
  - blink counter 0, blink_on=1
  - FSM enters SWEEP with idx=0 and busy=1
- After rst falls, the sweep runs ROWS*COLS cycles, so the buffer comes up blank (spaces).
- rst asserted mid-sweep restarts the sweep from idx 0.
- busy falls on the edge after the last cell is written. wr_en in that same cycle is accepted.

## Test plan
- Reset clear: hold rst 2 cycles, release → busy=1 for exactly 64 cycles (16×4). Then every text pixel equals vga_ascii(8'h20) output, enable=1 inside the panel.
- Write and read-back: write 8'h41 at row 2 col 5 → the pixel at (64+16+40+3, 64+16+32+7), sampled 3 cycles later, equals vga_ascii(8'h41,3,7).
- Regions and latency: sweep pos_x across x=63/64/303/304 at y=70 → pos_data 0/PANEL_COLOR/PANEL_COLOR/0 and enable 0/1/1/0, each exactly 3 cycles after input.
- Cursor blink with BLINK_HALF=4, cursor at (0,0) holding 8'h41:
  - pixel inverted for 4 cycles, normal for 4, repeating
  - cur_en=0 → never inverted
  - cur_col=16 → never inverted
- Drops and collisions:
  - wr_en during busy → cell unchanged
  - wr_row=4 → no write
  - clr and wr_en in the same idle cycle → write lost, busy rises next edge
- Mid-sweep reset: pulse rst at sweep idx 30 → busy stays high. Sweep completes 64 cycles after rst falls.
